// File: rtl/seq_gen_pkg.sv
// Shared types and sizing helpers for the serial pattern generator.
// Imported by the top level and the shift-register sub-module.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  localparam int GAP_CNT_W = 4;
  localparam int REPS_W    = 8;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_gen_piso_shreg.sv
// Parallel-in/serial-out register with a frozen image for reloading repetitions.
// The serial output is the bit at position sel-1 of the working register.
module piso_shreg
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LW      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               reload,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] din,
  input  logic [LW-1:0]      sel,
  output logic               dout
);

  logic [MAX_LEN-1:0] image;
  logic [MAX_LEN-1:0] data;
  logic [MAX_LEN-1:0] sel_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      image <= '0;
      data  <= '0;
    end else if (load) begin
      image <= din;
      data  <= din;
    end else if (reload) begin
      data <= image;
    end else if (shift) begin
      data <= {data[MAX_LEN-2:0], 1'b0};
    end
  end

  // Mask-based select keeps the index width independent of MAX_LEN.
  assign sel_mask = {{(MAX_LEN-1){1'b0}}, 1'b1} << (sel - LW'(1));
  assign dout     = |(data & sel_mask);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern generator: shifts a captured pattern out MSB (bit len-1)
// first, repeated reps+1 times with GAP idle cycles between repetitions.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int GAP     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [MAX_LEN-1:0]           pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic [REPS_W-1:0]            reps,
  output logic                         x,
  output logic                         x_valid,
  output logic                         frame,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int LW = len_width(MAX_LEN);

  state_t               state, state_nx;
  logic [LW-1:0]        len_q, len_nx;
  logic [LW-1:0]        bit_cnt, bit_cnt_nx;
  logic [REPS_W-1:0]    rep_cnt, rep_cnt_nx;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_nx;
  logic                 frame_q, frame_nx;
  logic                 err_q, err_nx;
  logic                 sh_load, sh_reload, sh_shift, sh_bit;
  logic                 len_ok;

  assign len_ok = (len != '0) && (len <= LW'(MAX_LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      len_q   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      len_q   <= len_nx;
      bit_cnt <= bit_cnt_nx;
      rep_cnt <= rep_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      frame_q <= frame_nx;
      err_q   <= err_nx;
    end
  end

  // bit_cnt holds the bits left in the current repetition, including the one on x.
  always_comb begin
    state_nx   = state;
    len_nx     = len_q;
    bit_cnt_nx = bit_cnt;
    rep_cnt_nx = rep_cnt;
    gap_cnt_nx = gap_cnt;
    frame_nx   = 1'b0;
    err_nx     = 1'b0;
    sh_load    = 1'b0;
    sh_reload  = 1'b0;
    sh_shift   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            sh_load    = 1'b1;
            len_nx     = len;
            bit_cnt_nx = len;
            rep_cnt_nx = reps;
            frame_nx   = 1'b1;
            state_nx   = S_SHIFT;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (bit_cnt > LW'(1)) begin
          sh_shift   = 1'b1;
          bit_cnt_nx = bit_cnt - LW'(1);
        end else if (rep_cnt == '0) begin
          state_nx = S_DONE;
        end else if (GAP == 0) begin
          sh_reload  = 1'b1;
          bit_cnt_nx = len_q;
          rep_cnt_nx = rep_cnt - REPS_W'(1);
          frame_nx   = 1'b1;
        end else begin
          gap_cnt_nx = GAP_CNT_W'(GAP - 1);
          state_nx   = S_GAP;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (gap_cnt == '0) begin
          sh_reload  = 1'b1;
          bit_cnt_nx = len_q;
          rep_cnt_nx = rep_cnt - REPS_W'(1);
          frame_nx   = 1'b1;
          state_nx   = S_SHIFT;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  piso_shreg #(
    .MAX_LEN(MAX_LEN),
    .LW     (LW)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .reload(sh_reload),
    .shift (sh_shift),
    .din   (pattern),
    .sel   (len_q),
    .dout  (sh_bit)
  );

  assign x       = (state == S_SHIFT) && sh_bit;
  assign x_valid = (state == S_SHIFT);
  assign frame   = frame_q;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench: two generators (GAP=2 and GAP=0) share stimulus and are
// compared every cycle against an arithmetic model of the output timeline.
module tb_seq_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [7:0]  reps = '0;

  logic x0, xv0, fr0, busy0, done0, err0;
  logic x1, xv1, fr1, busy1, done1, err1;

  int checks = 0;
  int errors = 0;

  seq_pattern_gen #(.MAX_LEN(16), .GAP(2)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .reps(reps), .x(x0), .x_valid(xv0), .frame(fr0), .busy(busy0),
    .done(done0), .err(err0)
  );

  seq_pattern_gen #(.MAX_LEN(16), .GAP(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .reps(reps), .x(x1), .x_valid(xv1), .frame(fr1), .busy(busy1),
    .done(done1), .err(err1)
  );

  initial begin
    #2;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: per instance, an active flag and the cycle offset t since acceptance.
  logic        act [2] = '{1'b0, 1'b0};
  logic        merr[2] = '{1'b0, 1'b0};
  int          mt  [2] = '{0, 0};
  int          mlen[2] = '{0, 0};
  int          mrep[2] = '{0, 0};
  logic [15:0] mpat[2] = '{16'h0, 16'h0};
  int          gaps[2] = '{2, 0};

  function automatic int totalLen(input int g, input int ln, input int rp);
    return (rp + 1) * ln + rp * g;
  endfunction

  // Returns {x, x_valid, frame, busy, done, err} for offset t of a transfer.
  function automatic logic [5:0] modelOut(input int g, input logic [15:0] pat,
                                          input int ln, input int rp, input int t);
    int k;
    if (t == totalLen(g, ln, rp)) return 6'b000110;
    k = t % (ln + g);
    if (k < ln) return {pat[ln-1-k], 1'b1, (k == 0), 1'b1, 1'b0, 1'b0};
    return 6'b000100;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        act[i]  = 1'b0;
        merr[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        merr[i] = 1'b0;
        if (act[i]) begin
          if (abort) act[i] = 1'b0;
          else begin
            mt[i]++;
            if (mt[i] > totalLen(gaps[i], mlen[i], mrep[i])) act[i] = 1'b0;
          end
        end else if (start && !abort) begin
          if (len >= 1 && len <= 16) begin
            act[i]  = 1'b1;
            mt[i]   = 0;
            mlen[i] = int'(len);
            mrep[i] = int'(reps);
            mpat[i] = pattern;
          end else begin
            merr[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] e0, e1;
    if (reset) begin
      e0 = act[0] ? modelOut(gaps[0], mpat[0], mlen[0], mrep[0], mt[0]) : {5'b0, merr[0]};
      e1 = act[1] ? modelOut(gaps[1], mpat[1], mlen[1], mrep[1], mt[1]) : {5'b0, merr[1]};
      checkOutput("cycle_dut0", {26'b0, x0, xv0, fr0, busy0, done0, err0}, {26'b0, e0});
      checkOutput("cycle_dut1", {26'b0, x1, xv1, fr1, busy1, done1, err1}, {26'b0, e1});
    end
  end

  task automatic applyStimulus(input logic st, input logic ab, input logic [15:0] pat,
                               input logic [4:0] ln, input logic [7:0] rp);
    @(negedge clk);
    start   = st;
    abort   = ab;
    pattern = pat;
    len     = ln;
    reps    = rp;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int c = 0;
    while ((busy0 || busy1) && c < bound) begin
      @(negedge clk);
      c++;
    end
    checkOutput("idle_timeout", {30'b0, busy0, busy1}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] vx, vv, vf, vd, vb;
    int ones, cnt0, cnt1;

    #10;
    checkOutput("reset_outputs", {26'b0, x0, xv0, fr0, busy0, done0, err0}, 32'd0);
    #5 reset = 1'b1;

    // 111 once: x = 1,1,1 then done
    applyStimulus(1'b1, 1'b0, 16'h0007, 5'd3, 8'd0);
    vx = '0; vd = '0; ones = 0;
    for (int c = 0; c < 4; c++) begin
      vx = {vx[30:0], x0};
      vd = {vd[30:0], done0};
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) if (vx[i+:3] == 3'b111) ones++;
    checkOutput("t1_x", vx, 32'b1110);
    checkOutput("t1_done", vd, 32'b0001);
    checkOutput("t1_111_hits", ones, 32'd1);
    waitIdle(50);

    // 1101 x3 with 2-cycle gaps
    applyStimulus(1'b1, 1'b0, 16'h000D, 5'd4, 8'd2);
    vx = '0; vv = '0; vf = '0; vd = '0;
    for (int c = 0; c < 17; c++) begin
      vx = {vx[30:0], x0};
      vv = {vv[30:0], xv0};
      vf = {vf[30:0], fr0};
      vd = {vd[30:0], done0};
      @(negedge clk);
    end
    checkOutput("t2_x", vx, 32'b11010011010011010);
    checkOutput("t2_xvalid", vv, 32'b11110011110011110);
    checkOutput("t2_frame", vf, 32'b10000010000010000);
    checkOutput("t2_done", vd, 32'b00000000000000001);
    waitIdle(50);

    // back-to-back repetitions on the GAP=0 instance
    applyStimulus(1'b1, 1'b0, 16'h0002, 5'd2, 8'd1);
    vx = '0; vf = '0; vd = '0;
    for (int c = 0; c < 5; c++) begin
      vx = {vx[30:0], x1};
      vf = {vf[30:0], fr1};
      vd = {vd[30:0], done1};
      @(negedge clk);
    end
    checkOutput("t3_x", vx, 32'b10100);
    checkOutput("t3_frame", vf, 32'b10100);
    checkOutput("t3_done", vd, 32'b00001);
    waitIdle(50);

    // invalid lengths
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 5'd0, 8'd0);
    checkOutput("t4_len0_err_busy", {30'b0, err0, busy0}, 32'b10);
    @(negedge clk);
    checkOutput("t4_len0_pulse", {31'b0, err0}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 5'd17, 8'd0);
    checkOutput("t4_len17_err_busy", {30'b0, err0, busy0}, 32'b10);
    @(negedge clk);

    // start and new pattern while busy are ignored
    applyStimulus(1'b1, 1'b0, 16'h000B, 5'd4, 8'd1);
    vx = '0;
    for (int c = 0; c < 11; c++) begin
      vx = {vx[30:0], x0};
      if (c == 2) begin
        start = 1'b1; pattern = 16'h0000; len = 5'd1; reps = 8'd0;
      end
      if (c == 3) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("t5_x", vx, 32'b10110010110);
    waitIdle(50);

    // abort during bit 2 of 5
    applyStimulus(1'b1, 1'b0, 16'h0016, 5'd5, 8'd0);
    vb = '0; vd = '0;
    for (int c = 0; c < 5; c++) begin
      vb = {vb[30:0], busy0};
      vd = {vd[30:0], done0};
      if (c == 2) abort = 1'b1;
      if (c == 3) abort = 1'b0;
      @(negedge clk);
    end
    checkOutput("t6_busy", vb, 32'b11100);
    checkOutput("t6_done", vd, 32'b00000);
    waitIdle(20);

    // async reset in the middle of a gap
    applyStimulus(1'b1, 1'b0, 16'h000D, 5'd4, 8'd1);
    repeat (4) @(negedge clk);
    checkOutput("t7_in_gap", {30'b0, busy0, xv0}, 32'b10);
    #2 reset = 1'b0;
    #1;
    checkOutput("t7_async_dut0", {26'b0, x0, xv0, fr0, busy0, done0, err0}, 32'd0);
    checkOutput("t7_async_dut1", {26'b0, x1, xv1, fr1, busy1, done1, err1}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // 256 repetitions
    applyStimulus(1'b1, 1'b0, 16'h0002, 5'd2, 8'd255);
    cnt0 = 1; cnt1 = 1;
    for (int c = 0; c < 1100 && (busy0 || busy1); c++) begin
      @(negedge clk);
      if (xv0) cnt0++;
      if (xv1) cnt1++;
    end
    checkOutput("t8_bits_dut0", cnt0, 32'd512);
    checkOutput("t8_bits_dut1", cnt1, 32'd512);
    waitIdle(10);

    // randomized transfers with noise starts and occasional aborts
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'b1, 1'b0, 16'($urandom()), 5'($urandom_range(0, 18)),
                    ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3)));
      for (int c = 0; c < 3000; c++) begin
        if (!busy0 && !busy1) break;
        start   = ($urandom_range(0, 7) == 0);
        abort   = ($urandom_range(0, 59) == 0);
        pattern = 16'($urandom());
        len     = 5'($urandom_range(0, 18));
        reps    = 8'($urandom_range(0, 3));
        @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      waitIdle(10);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern generator: the transmit side of the serial sequence detectors in the sequential-logic set. It captures a programmable pattern of up to MAX_LEN bits and shifts it out one bit per clock on `x`, optionally repeated with idle gaps between repetitions, under a start/busy/done handshake. Its `x` output drives a detector's `x` input directly, so detector benches can use a synthesizable stimulus source in place of hand-timed `#delay` vectors.

## Interface
- MAX_LEN, 16: maximum pattern length in bits (2..32).
- GAP, 2: idle cycles between repetitions (0..15). 0 means back-to-back repetitions.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin. Sampled only in IDLE.
- abort  input  1  synchronous stop. Returns to IDLE with no `done`.
- pattern  input  MAX_LEN  bits to send. Bit `len-1` is sent first and bit 0 last.
- len  input  $clog2(MAX_LEN+1)  number of bits to send per repetition (1..MAX_LEN).
- reps  input  8  additional repetitions; 0 sends the pattern once.
- x  output  1  serial data, registered.
- x_valid  output  1  high while `x` carries a pattern bit.
- frame  output  1  high with the first bit of each repetition.
- busy  output  1  high from the accepted start through the DONE cycle.
- done  output  1  one-cycle pulse on completion.
- err  output  1  one-cycle pulse when a start is rejected.

## Operation
- Moore FSM with states IDLE, SHIFT, GAP and DONE. All outputs are registered and decoded from state and datapath registers only.
- IDLE:
  - If `start` is high and `len` is in 1..MAX_LEN: capture `pattern`, `len` and `reps`, then go to SHIFT. The first bit is loaded so that it appears on `x` in the same edge.
  - If `start` is high and `len` is 0 or greater than MAX_LEN: `err` is 1 for one cycle and the state stays IDLE.
- SHIFT:
  - Emits one bit per cycle with `x_valid` = 1.
  - The bit counter counts down from `len`.
  - When the last bit of a repetition has been emitted:
    - remaining reps > 0 and GAP > 0: go to GAP.
    - remaining reps > 0 and GAP = 0: reload the shift register and stay in SHIFT. `frame` is 1 with the reloaded first bit.
    - remaining reps = 0: go to DONE.
- GAP:
  - `x` = 0 and `x_valid` = 0 for exactly GAP cycles.
  - Then reload the shift register, decrement reps and go to SHIFT.
- DONE: `done` = 1, `busy` = 1, `x` = 0 and `x_valid` = 0 for one cycle, then go to IDLE.
- Captured values are frozen while busy. Changes on `pattern`, `len` or `reps` while busy have no effect.
- `start` while busy is ignored: no `err`, no restart.
- `abort` is honoured in SHIFT, GAP and DONE. On the next edge the state is IDLE, `x`, `x_valid`, `frame` and `busy` are 0, and `done` is not pulsed. If `abort` and `start` are both high in IDLE, `abort` wins and the start is dropped.
- `reps` = 255 gives 256 repetitions in total. The counter must not wrap.

## Timing
- Reset (asynchronous, `reset` = 0): state is IDLE and `x`, `x_valid`, `frame`, `busy`, `done` and `err` are all 0, immediately and independent of `clk`.
- Reset mid-transfer has the same effect. After reset release the first edge is a normal IDLE cycle.
- Start accepted at edge E0: after E0, `x` = `pattern[len-1]`, `x_valid` = 1, `frame` = 1 and `busy` = 1.
- Bit k of a repetition (k = 0..len-1) is visible after edge E0+k for the first repetition.
- Repetition r starts at edge E0 + r·(len+GAP).
- DONE is visible after edge E0 + (reps+1)·len + reps·GAP. `busy` falls one edge later.
- The earliest next start is sampled on the edge after `busy` falls.
- `err` is visible after the edge that sampled the invalid start.

## Structure
- Shared package `seq_gen_pkg` holds:
  - state enum {IDLE, SHIFT, GAP, DONE};
  - localparams for the `len` width and the gap-counter width.
- One sub-module, `piso_shreg`: a MAX_LEN parallel-in/serial-out register with load enable, shift enable and MSB-at-`len-1` output select.
- Counters and FSM live in the top level.

## Test plan
- Reset held low for 15 ns, then released; start with `pattern` = 3'b111, `len` = 3, `reps` = 0 -> `x` = 1,1,1 on three consecutive cycles, `done` on the 4th. A connected 111 detector must assert `z` exactly once.
- `pattern` = 4'b1101, `len` = 4, `reps` = 2, GAP = 2 -> `x` = 1101,0 0,1101,0 0,1101 with `x_valid` low in the gaps. `frame` is high at cycles 0, 6 and 12; `done` at cycle 16.
- GAP = 0, `pattern` = 2'b10, `len` = 2, `reps` = 1 -> `x` = 1,0,1,0 back-to-back with `frame` at cycles 0 and 2.
- `len` = 0, then `len` = MAX_LEN+1 -> one `err` pulse each, `busy` stays 0.
- `start` pulsed and `pattern` changed mid-transfer -> output unchanged and no restart.
- `abort` at bit 2 of 5 -> IDLE next edge with no `done`.
- Async `reset` asserted mid-GAP -> all outputs 0 before the next edge.
